// File: rtl/obj_list_if.sv
// obj_list_if: command/response bundle for the object-list manager.
// master drives commands, slave accepts them and answers.
interface obj_list_if #(
  parameter int OBJ_WIDTH = 56,
  parameter int IDX_W     = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [IDX_W-1:0]     cmd_idx;
  logic [OBJ_WIDTH-1:0] cmd_obj;
  logic                 resp_valid;
  logic                 resp_err;
  logic [IDX_W-1:0]     resp_idx;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_obj,
    input  cmd_ready, resp_valid, resp_err, resp_idx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_obj,
    output cmd_ready, resp_valid, resp_err, resp_idx
  );
endinterface

// File: rtl/obj_list_mgr.sv
// obj_list_mgr: edits a working object list, publishes it to the
// renderer's display copy only at frame start.
module obj_list_mgr #(
  parameter int OBJ_WIDTH = 56,
  parameter int MAX_LEN   = 16,
  parameter int IDX_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  obj_list_if.slave                    cmd,
  output logic [OBJ_WIDTH*MAX_LEN-1:0] obj_arr_packed,
  output logic [5:0]                   obj_arr_len
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [5:0] FULL = 6'(MAX_LEN);

  logic [0:0]           state;
  logic [OBJ_WIDTH-1:0] work [MAX_LEN];
  logic [OBJ_WIDTH-1:0] disp [MAX_LEN];
  logic [5:0]           wlen;
  logic [5:0]           dlen;
  logic [5:0]           ptr;
  logic                 dirty;

  logic                 accept;
  logic                 commit;
  logic [5:0]           idx_x;
  logic                 idx_ok;
  logic                 is_add;
  logic                 is_set;
  logic                 is_del;
  logic                 is_clr;
  logic                 is_shift;
  logic                 more;
  logic [IDX_W-1:0]     wl_i;
  logic [IDX_W-1:0]     p_i;
  logic [IDX_W-1:0]     p_n;

  assign cmd.cmd_ready = (state == S_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign commit        = frame_start && (state == S_IDLE) && dirty;
  assign idx_x         = 6'(cmd.cmd_idx);
  assign idx_ok        = idx_x < wlen;

  assign is_add   = accept && (cmd.cmd_op == OP_ADD);
  assign is_set   = accept && (cmd.cmd_op == OP_SET);
  assign is_del   = accept && (cmd.cmd_op == OP_DEL);
  assign is_clr   = accept && (cmd.cmd_op == OP_CLR);
  assign is_shift = (state == S_SHIFT);

  // ptr+1 stays in range: a shift step only runs while ptr < wlen-1
  assign more = ptr < (wlen - 6'd1);
  assign wl_i = wlen[IDX_W-1:0];
  assign p_i  = ptr[IDX_W-1:0];
  assign p_n  = IDX_W'(ptr + 6'd1);

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign obj_arr_packed[g*OBJ_WIDTH +: OBJ_WIDTH] = disp[g];
  end

  assign obj_arr_len = dlen;

  // Command execution, delete compaction and frame-start publish
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        work[i] <= '0;
        disp[i] <= '0;
      end
      wlen           <= '0;
      dlen           <= '0;
      ptr            <= '0;
      dirty          <= 1'b0;
      state          <= S_IDLE;
      cmd.resp_valid <= 1'b0;
      cmd.resp_err   <= 1'b0;
      cmd.resp_idx   <= '0;
    end else begin
      cmd.resp_valid <= 1'b0;
      cmd.resp_err   <= 1'b0;

      // publish uses pre-command values; a same-edge edit re-dirties
      if (commit) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          disp[i] <= work[i];
        end
        dlen  <= wlen;
        dirty <= 1'b0;
      end

      unique case (1'b1)
        is_add: begin
          cmd.resp_valid <= 1'b1;
          cmd.resp_idx   <= wl_i;
          if (wlen < FULL) begin
            work[wl_i] <= cmd.cmd_obj;
            wlen       <= wlen + 6'd1;
            dirty      <= 1'b1;
          end else begin
            cmd.resp_err <= 1'b1;
          end
        end
        is_set: begin
          cmd.resp_valid <= 1'b1;
          cmd.resp_idx   <= cmd.cmd_idx;
          if (idx_ok) begin
            work[cmd.cmd_idx] <= cmd.cmd_obj;
            dirty             <= 1'b1;
          end else begin
            cmd.resp_err <= 1'b1;
          end
        end
        is_del: begin
          cmd.resp_idx <= cmd.cmd_idx;
          if (idx_ok) begin
            ptr   <= idx_x;
            state <= S_SHIFT;
          end else begin
            cmd.resp_valid <= 1'b1;
            cmd.resp_err   <= 1'b1;
          end
        end
        is_clr: begin
          for (int i = 0; i < MAX_LEN; i++) begin
            work[i] <= '0;
          end
          wlen           <= '0;
          dirty          <= 1'b1;
          cmd.resp_valid <= 1'b1;
          cmd.resp_idx   <= '0;
        end
        is_shift: begin
          if (more) begin
            work[p_i] <= work[p_n];
            ptr       <= ptr + 6'd1;
          end else begin
            work[p_i]      <= '0;
            wlen           <= wlen - 6'd1;
            dirty          <= 1'b1;
            cmd.resp_valid <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_list_mgr.sv
// tb_obj_list_mgr: directed + random commands against a queue model
// of the working/display lists.
module tb_obj_list_mgr;
  localparam int W = 56;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start;
  logic [W*N-1:0] arr;
  logic [5:0]   alen;

  obj_list_if #(.OBJ_WIDTH(W), .IDX_W(4)) bus ();

  obj_list_mgr #(.OBJ_WIDTH(W), .MAX_LEN(N), .IDX_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .cmd            (bus),
    .obj_arr_packed (arr),
    .obj_arr_len    (alen)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] dq[$];
  bit           mdirty;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] robj();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic check_disp(input string tag);
    logic [63:0] e;
    chk({tag, ".len"}, 64'(alen), 64'(dq.size()));
    for (int i = 0; i < N; i++) begin
      e = (i < dq.size()) ? 64'(dq[i]) : 64'd0;
      chk($sformatf("%s.slot%0d", tag, i), 64'(arr[i*W +: W]), e);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    if (mdirty) begin
      dq = mq;
      mdirty = 1'b0;
    end
    #1 frame_start = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input int idx,
                        input logic [W-1:0] obj, input bit fs,
                        input bit fs_shift);
    int len;
    int lat;
    int ridx;
    bit err;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = 4'(idx);
    bus.cmd_obj   = obj;
    frame_start   = fs;
    chk("ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    if (fs && mdirty) begin
      dq = mq;
      mdirty = 1'b0;
    end
    len  = mq.size();
    lat  = 1;
    err  = 1'b0;
    ridx = idx;
    case (op)
      2'd0: begin
        ridx = len;
        if (len < N) begin
          mq.push_back(obj);
          mdirty = 1'b1;
        end else err = 1'b1;
      end
      2'd1: begin
        if (idx < len) begin
          mq[idx] = obj;
          mdirty = 1'b1;
        end else err = 1'b1;
      end
      2'd2: begin
        if (idx < len) begin
          mq.delete(idx);
          mdirty = 1'b1;
          lat = 2 + (len - 1 - idx);
        end else err = 1'b1;
      end
      default: begin
        mq.delete();
        mdirty = 1'b1;
        ridx = 0;
      end
    endcase
    #1;
    bus.cmd_valid = 1'b0;
    frame_start   = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chk("busy", 64'(bus.cmd_ready), 64'd0);
      chk("early_resp", 64'(bus.resp_valid), 64'd0);
      if (k == 1) frame_start = fs_shift;
      @(posedge clk);
      #1 frame_start = 1'b0;
    end
    chk("resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("resp_err", 64'(bus.resp_err), 64'(err));
    if (!(err && op == 2'd0))
      chk("resp_idx", 64'(bus.resp_idx), 64'(ridx));
    chk("ready_after", 64'(bus.cmd_ready), 64'd1);
    chk("len_hold", 64'(alen), 64'(dq.size()));
  endtask

  logic [W-1:0] oa, ob, oc, od;

  initial begin
    oa = {4'd1, 10'd100, 10'd50, 10'd20, 10'd20, 12'h0F0};
    ob = {4'd2, 10'd200, 10'd60, 10'd30, 10'd10, 12'hFFF};
    oc = {4'd1, 10'd300, 10'd70, 10'd40, 10'd15, 12'hF00};
    od = {4'd3, 10'd400, 10'd80, 10'd12, 10'd12, 12'h00F};
    rst = 1'b1;
    frame_start = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op  = 2'd0;
    bus.cmd_idx = 4'd0;
    bus.cmd_obj = '0;
    mdirty = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_resp", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_post_rst", 64'(bus.cmd_ready), 64'd1);
    chk("rst_err", 64'(bus.resp_err), 64'd0);
    chk("rst_idx", 64'(bus.resp_idx), 64'd0);
    check_disp("rst");

    do_cmd(2'd0, 0, oa, 0, 0);
    do_cmd(2'd0, 0, ob, 0, 0);
    do_cmd(2'd0, 0, oc, 0, 0);
    check_disp("abc_pre");
    frame();
    check_disp("abc");

    do_cmd(2'd3, 0, '0, 0, 0);
    for (int i = 0; i < N; i++) do_cmd(2'd0, 0, robj(), 0, 0);
    do_cmd(2'd0, 0, robj(), 0, 0);
    frame();
    check_disp("full");

    do_cmd(2'd3, 0, '0, 0, 0);
    do_cmd(2'd0, 0, oa, 0, 0);
    do_cmd(2'd0, 0, ob, 0, 0);
    do_cmd(2'd0, 0, oc, 0, 0);
    do_cmd(2'd0, 0, od, 0, 0);
    frame();
    check_disp("abcd");
    do_cmd(2'd2, 1, '0, 0, 0);
    frame();
    check_disp("del1");

    do_cmd(2'd1, 5, robj(), 0, 0);
    frame();
    check_disp("set_err");
    do_cmd(2'd1, 2, robj(), 0, 0);
    check_disp("set_pre");
    frame();
    check_disp("set2");

    do_cmd(2'd1, 0, robj(), 0, 0);
    do_cmd(2'd0, 0, robj(), 1, 0);
    check_disp("fs_add");
    frame();
    check_disp("fs_add_next");

    do_cmd(2'd2, 0, '0, 0, 1);
    check_disp("fs_shift");
    frame();
    check_disp("fs_shift_next");

    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      int idx;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3 && $urandom_range(0, 3) != 0) op = 2'd0;
      idx = $urandom_range(0, 15);
      if (mq.size() > 0 && ($urandom % 2) == 0)
        idx = $urandom_range(0, mq.size() - 1);
      do_cmd(op, idx, robj(), $urandom_range(0, 3) == 0,
             ($urandom % 2) == 1);
      if ($urandom_range(0, 4) == 0) begin
        frame();
        check_disp("rnd");
      end
    end
    frame();
    check_disp("rnd_end");

    do_cmd(2'd3, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) do_cmd(2'd0, 0, robj(), 0, 0);
    frame();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_idx   = 4'd0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    chk("mid_busy", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    dq.delete();
    mdirty = 1'b0;
    chk("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
    chk("mid_rst_resp", 64'(bus.resp_valid), 64'd0);
    check_disp("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("mid_no_resp", 64'(bus.resp_valid), 64'd0);
    do_cmd(2'd0, 0, oa, 0, 0);
    frame();
    check_disp("post_rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
